// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for the ALU op sequencer.
// The master issues {op, a, b} and consumes {result, err}.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command front end for the slice ALU.
// Mod (op 111) runs as an SLT/SUB loop through the ALU.
module alu_op_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(MAX_ITER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_ITER);

  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CMP,
    S_SUB,
    S_RESP
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             err_q;

  logic accept;
  logic is_mod;
  logic mod_bad;
  logic rem_lt;
  logic at_max;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign is_mod  = (bus.req_op == OP_MOD);
  // Slt is signed, so a negative operand would never terminate sensibly.
  assign mod_bad = (bus.req_b == '0)
                 | bus.req_a[WIDTH-1]
                 | bus.req_b[WIDTH-1];
  assign rem_lt  = alu_result[0];
  assign at_max  = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!is_mod)      state_n = S_EXEC;
          else if (mod_bad) state_n = S_RESP;
          else              state_n = S_CMP;
        end
      end
      S_EXEC: state_n = S_RESP;
      S_CMP: begin
        if (rem_lt || at_max) state_n = S_RESP;
        else                  state_n = S_SUB;
      end
      S_SUB:  state_n = S_CMP;
      S_RESP: begin
        if (bus.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_op        = 3'b000;
    alu_a         = '0;
    alu_b         = '0;
    unique case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_EXEC: begin
        alu_op = op_q;
        alu_a  = rem_q;
        alu_b  = b_q;
      end
      S_CMP: begin
        alu_op = OP_SLT;
        alu_a  = rem_q;
        alu_b  = b_q;
      end
      S_SUB: begin
        alu_op = OP_SUB;
        alu_a  = rem_q;
        alu_b  = b_q;
      end
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // rem_q doubles as operand A for single-pass ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 3'b000;
      rem_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= bus.req_op;
            rem_q <= bus.req_a;
            b_q   <= bus.req_b;
            cnt_q <= '0;
            if (is_mod && mod_bad) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          res_q <= alu_result;
          err_q <= 1'b0;
        end
        S_CMP: begin
          if (rem_lt) begin
            res_q <= rem_q;
            err_q <= 1'b0;
          end else if (at_max) begin
            res_q <= rem_q;
            err_q <= 1'b1;
          end
        end
        S_SUB: begin
          rem_q <= alu_result;
          if (!at_max) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_result = res_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a transaction-level
// reference model and a per-cycle output compare process.
module tb_alu_op_sequencer;

  localparam int W  = 32;
  localparam int MX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .MAX_ITER(MX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_f(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a ^ b;
      3'b011: return ~(a | b);
      3'b100: return {31'd0, ($signed(a) < $signed(b))};
      3'b101: return a + b;
      3'b110: return a - b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

  // Whole-transaction model: result, error and latency in cycles.
  function automatic void model(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
    output logic [W-1:0] r, output logic e, output int lat);
    longint unsigned q;
    e = 1'b0;
    if (op != 3'b111) begin
      r   = alu_f(op, a, b);
      lat = 2;
    end else if (b == 0 || a[W-1] || b[W-1]) begin
      r   = '0;
      e   = 1'b1;
      lat = 1;
    end else begin
      q = longint'(a) / longint'(b);
      if (q <= MX) begin
        r   = a % b;
        lat = 2 + 2 * int'(q);
      end else begin
        r   = a - W'(MX) * b;
        e   = 1'b1;
        lat = 2 + 2 * MX;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  bit           active = 0;
  int           t_acc;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b, m_r;
  logic         m_e;
  int           m_lat;

  always @(negedge clk) begin
    int o;
    if (!rst_n) begin
      active = 0;
      chk("rst_req_ready", W'(bus.req_ready), 1);
      chk("rst_rsp_valid", W'(bus.rsp_valid), 0);
      chk("rst_alu_op", W'(alu_op), 0);
    end else begin
      if (!active) begin
        chk("idle_req_ready", W'(bus.req_ready), 1);
        chk("idle_rsp_valid", W'(bus.rsp_valid), 0);
        chk("idle_alu_op", W'(alu_op), 0);
        chk("idle_alu_a", alu_a, 0);
        chk("idle_alu_b", alu_b, 0);
      end else begin
        o = cyc - t_acc;
        chk("busy_req_ready", W'(bus.req_ready), 0);
        if (o < m_lat - 1) begin
          chk("busy_rsp_valid", W'(bus.rsp_valid), 0);
          if (m_op != 3'b111) begin
            chk("exec_alu_op", W'(alu_op), W'(m_op));
            chk("exec_alu_a", alu_a, m_a);
          end else begin
            chk("mod_alu_op", W'(alu_op),
                (o % 2 == 0) ? W'(3'b100) : W'(3'b110));
            chk("mod_alu_a", alu_a, m_a - W'(o / 2) * m_b);
          end
          chk("busy_alu_b", alu_b, m_b);
        end else begin
          chk("resp_valid", W'(bus.rsp_valid), 1);
          chk("resp_result", bus.rsp_result, m_r);
          chk("resp_err", W'(bus.rsp_err), W'(m_e));
          chk("resp_alu_op", W'(alu_op), 0);
        end
      end
      if (!active && bus.req_valid) begin
        active = 1;
        t_acc  = cyc + 1;
        m_op   = bus.req_op;
        m_a    = bus.req_a;
        m_b    = bus.req_b;
        model(m_op, m_a, m_b, m_r, m_e, m_lat);
      end else if (active && (cyc - t_acc) >= m_lat - 1 && bus.rsp_ready) begin
        active = 0;
      end
    end
  end

  logic [W-1:0] r;
  logic         e;
  int           lat;

  task automatic run(input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int stall,
                     output logic [W-1:0] res, output logic err,
                     output int l);
    int  acc;
    bit  seen;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    if (stall > 0) bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    acc  = cyc;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    if (!seen) begin
      chk("rsp_timeout", 0, 1);
      res = '0;
      err = 1'b0;
      l   = -1;
      bus.rsp_ready = 1'b1;
      return;
    end
    res = bus.rsp_result;
    err = bus.rsp_err;
    l   = cyc - acc + 1;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk("stall_valid", W'(bus.rsp_valid), 1);
      chk("stall_result", bus.rsp_result, res);
      chk("stall_err", W'(bus.rsp_err), W'(err));
      chk("stall_req_ready", W'(bus.req_ready), 0);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic expect3(input string nm,
                         input logic [W-1:0] er, input logic ee, input int el);
    chk({nm, "_res"}, r, er);
    chk({nm, "_err"}, W'(e), W'(ee));
    chk({nm, "_lat"}, W'(lat), W'(el));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", W'(bus.req_ready), 1);
    chk("reset_rsp_valid", W'(bus.rsp_valid), 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_err", W'(bus.rsp_err), 0);
    chk("reset_alu_op", W'(alu_op), 0);
    chk("reset_alu_a", alu_a, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run(3'b000, 32'h0000F0F0, 32'h00000FF0, 0, r, e, lat);
    expect3("and", 32'h000000F0, 0, 2);
    run(3'b110, 32'd5, 32'd7, 0, r, e, lat);
    expect3("sub", 32'hFFFFFFFE, 0, 2);
    run(3'b100, 32'hFFFFFFFF, 32'd1, 0, r, e, lat);
    expect3("slt", 32'd1, 0, 2);
    run(3'b001, 32'h00F0_0000, 32'h0000_000F, 0, r, e, lat);
    expect3("or", 32'h00F0000F, 0, 2);
    run(3'b010, 32'hFF00FF00, 32'h0FF00FF0, 0, r, e, lat);
    expect3("xor", 32'hF0F0F0F0, 0, 2);
    run(3'b011, 32'hFFFF0000, 32'h000000FF, 0, r, e, lat);
    expect3("nor", 32'h0000FF00, 0, 2);
    run(3'b101, 32'hFFFFFFFF, 32'd1, 0, r, e, lat);
    expect3("add_wrap", 32'd0, 0, 2);

    run(3'b111, 32'd17, 32'd5, 0, r, e, lat);
    expect3("mod17_5", 32'd2, 0, 8);
    run(3'b111, 32'd3, 32'd7, 0, r, e, lat);
    expect3("mod_lt", 32'd3, 0, 2);
    run(3'b111, 32'd9, 32'd9, 0, r, e, lat);
    expect3("mod_eq", 32'd0, 0, 4);
    run(3'b111, 32'd9, 32'd0, 0, r, e, lat);
    expect3("mod_b0", 32'd0, 1, 1);
    run(3'b111, 32'h80000004, 32'd3, 0, r, e, lat);
    expect3("mod_neg", 32'd0, 1, 1);
    run(3'b111, 32'd100, 32'd1, 0, r, e, lat);
    expect3("mod_max", 32'd96, 1, 10);
    run(3'b111, 32'd20, 32'd5, 0, r, e, lat);
    expect3("mod_at_max", 32'd0, 0, 10);

    run(3'b101, 32'd40, 32'd2, 10, r, e, lat);
    expect3("stall_add", 32'd42, 0, 2);

    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b111;
    bus.req_a     = 32'd17;
    bus.req_b     = 32'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_sub", W'(alu_op), W'(3'b110));
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_op", W'(alu_op), 0);
    chk("midrst_rsp_valid", W'(bus.rsp_valid), 0);
    chk("midrst_req_ready", W'(bus.req_ready), 1);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", W'(bus.rsp_valid), 0);

    run(3'b111, 32'd14, 32'd4, 0, r, e, lat);
    expect3("mod_after_rst", 32'd2, 0, 8);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
